// File: rtl/key_hold_encoder_pkg.sv
// Shared constants and ASCII decode for the held-key encoder.
// Key bit order: W S A D J K L SPACE (bit 7 down to bit 0).
package key_pkg;

  localparam int unsigned NUM_KEYS            = 8;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 60_000_000;

  localparam int unsigned KEY_W     = 7;
  localparam int unsigned KEY_S     = 6;
  localparam int unsigned KEY_A     = 5;
  localparam int unsigned KEY_D     = 4;
  localparam int unsigned KEY_J     = 3;
  localparam int unsigned KEY_K     = 2;
  localparam int unsigned KEY_L     = 1;
  localparam int unsigned KEY_SPACE = 0;

  localparam logic [7:0] ASC_W_UP  = 8'h57;
  localparam logic [7:0] ASC_W_LO  = 8'h77;
  localparam logic [7:0] ASC_S_UP  = 8'h53;
  localparam logic [7:0] ASC_S_LO  = 8'h73;
  localparam logic [7:0] ASC_A_UP  = 8'h41;
  localparam logic [7:0] ASC_A_LO  = 8'h61;
  localparam logic [7:0] ASC_D_UP  = 8'h44;
  localparam logic [7:0] ASC_D_LO  = 8'h64;
  localparam logic [7:0] ASC_J_UP  = 8'h4A;
  localparam logic [7:0] ASC_J_LO  = 8'h6A;
  localparam logic [7:0] ASC_K_UP  = 8'h4B;
  localparam logic [7:0] ASC_K_LO  = 8'h6B;
  localparam logic [7:0] ASC_L_UP  = 8'h4C;
  localparam logic [7:0] ASC_L_LO  = 8'h6C;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  // One-hot key for a received byte; all zeros for unrecognised bytes.
  function automatic logic [NUM_KEYS-1:0] decode_key(input logic [7:0] b);
    logic [NUM_KEYS-1:0] k;
    k = '0;
    case (b)
      ASC_W_UP, ASC_W_LO: k[KEY_W]     = 1'b1;
      ASC_S_UP, ASC_S_LO: k[KEY_S]     = 1'b1;
      ASC_A_UP, ASC_A_LO: k[KEY_A]     = 1'b1;
      ASC_D_UP, ASC_D_LO: k[KEY_D]     = 1'b1;
      ASC_J_UP, ASC_J_LO: k[KEY_J]     = 1'b1;
      ASC_K_UP, ASC_K_LO: k[KEY_K]     = 1'b1;
      ASC_L_UP, ASC_L_LO: k[KEY_L]     = 1'b1;
      ASC_SPACE:          k[KEY_SPACE] = 1'b1;
      default:            k            = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/key_hold_encoder_if.sv
// Receive-byte / held-key bundle between the UART receive path and the encoder.
interface key_hold_encoder_if;
  import key_pkg::*;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_press;

  modport master (output rx_data, output rx_valid, input key, input key_press);
  modport slave  (input rx_data, input rx_valid, output key, output key_press);
endinterface

// File: rtl/key_hold_encoder_timer.sv
// One reloadable saturating down-counter per key; held while nonzero,
// press pulses when a load arrives on an idle counter.
module key_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 60_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic held,
  output logic press
);
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Load wins over clear and over the countdown, so a re-press never gaps.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (load) begin
      cnt_d   = CNT_W'(HOLD_CYCLES);
      press_d = (cnt_q == '0);
    end else if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign held  = (cnt_q != '0);
  assign press = press_q;

endmodule

// File: rtl/key_hold_encoder.sv
// Turns received keyboard bytes into a held-key vector with per-key hold timers.
// Define KEY_HOLD_EXCLUSIVE_EN to make a new key release all other keys.
module key_hold_encoder
  import key_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  key_hold_encoder_if.slave   bus
);

  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] clr;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] press;

  always_comb begin
    hit = bus.rx_valid ? decode_key(bus.rx_data) : '0;
`ifdef KEY_HOLD_EXCLUSIVE_EN
    // Only a recognised byte clears the others.
    clr = (hit != '0) ? ~hit : '0;
`else
    clr = '0;
`endif
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_timer
    key_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (hit[i]),
      .clear (clr[i]),
      .held  (held[i]),
      .press (press[i])
    );
  end

  assign bus.key       = held;
  assign bus.key_press = press;

endmodule

// File: tb/tb_key_hold_encoder.sv
// Self-checking bench for key_hold_encoder: directed vector table plus
// randomized traffic against a timestamp-based reference model.
module tb_key_hold_encoder;
  localparam int Hold = 10;
`ifdef KEY_HOLD_EXCLUSIVE_EN
  localparam bit Excl = 1'b1;
`else
  localparam bit Excl = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         rst;
    bit         v;
    logic [7:0] d;
    logic [7:0] ek;
    logic [7:0] ep;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  key_hold_encoder_if bus ();

  key_hold_encoder #(
    .HOLD_CYCLES (Hold)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Model state: cycle of the last accepted byte per key, and whether one exists.
  int last_t[8];
  bit have[8];
  int t_now;

  function automatic void add(string n, bit r, bit v, logic [7:0] d, logic [7:0] ek,
                              logic [7:0] ep);
    vec_t x;
    x.name = n; x.rst = r; x.v = v; x.d = d; x.ek = ek; x.ep = ep;
    vecs.push_back(x);
  endfunction

  function automatic void add_idle(string n, int count, logic [7:0] ek);
    for (int i = 0; i < count; i++) add(n, 1'b0, 1'b0, 8'h00, ek, 8'h00);
  endfunction

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    reset        = r;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [7:0] ek, input logic [7:0] ep);
    n_total++;
    if (bus.key === ek && bus.key_press === ep) n_pass++;
    else $display("FAIL %s @%0t: key=%h press=%h, required key=%h press=%h",
                  n, $time, bus.key, bus.key_press, ek, ep);
  endtask

  // Bit index of the key named by a byte, or -1; letters folded to lower case.
  function automatic int model_idx(input logic [7:0] d);
    logic [7:0] c;
    logic [7:0] names[8];
    names = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h6A, 8'h6B, 8'h6C, 8'h20};
    c = d;
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
    for (int p = 0; p < 8; p++) if (names[p] == c) return 7 - p;
    return -1;
  endfunction

  function automatic bit model_held(input int i, input int t);
    return have[i] && (t - last_t[i] >= 1) && (t - last_t[i] <= Hold);
  endfunction

  initial begin
    logic [7:0] keys_tbl[8];
    keys_tbl = '{8'h57, 8'h73, 8'h41, 8'h64, 8'h4A, 8'h6B, 8'h4C, 8'h20};

    // Reset overrides a valid byte.
    add("reset", 1'b1, 1'b1, 8'h77, 8'h00, 8'h00);
    add("reset", 1'b1, 1'b1, 8'h77, 8'h00, 8'h00);
    add_idle("reset_after", 1, 8'h00);
    // Single press: held exactly Hold cycles.
    add("single", 1'b0, 1'b1, 8'h77, 8'h80, 8'h80);
    add_idle("single_hold", Hold - 1, 8'h80);
    add_idle("single_end", 1, 8'h00);
    // Re-press mid-hold: no gap, no second pulse.
    add("repress", 1'b0, 1'b1, 8'h57, 8'h80, 8'h80);
    add_idle("repress_hold", 8, 8'h80);
    add("repress_2nd", 1'b0, 1'b1, 8'h57, 8'h80, 8'h00);
    add_idle("repress_hold2", Hold - 1, 8'h80);
    add_idle("repress_end", 1, 8'h00);
    // Re-press on the last held cycle (counter at 1).
    add("edge", 1'b0, 1'b1, 8'h20, 8'h01, 8'h01);
    add_idle("edge_hold", Hold - 1, 8'h01);
    add("edge_reload", 1'b0, 1'b1, 8'h20, 8'h01, 8'h00);
    add_idle("edge_hold2", Hold - 1, 8'h01);
    add_idle("edge_end", 1, 8'h00);
    // Two keys overlapping.
    add("multi_a", 1'b0, 1'b1, 8'h61, 8'h20, 8'h20);
    add_idle("multi_a_hold", 1, 8'h20);
    add("multi_sp", 1'b0, 1'b1, 8'h20, Excl ? 8'h01 : 8'h21, 8'h01);
    add_idle("multi_both", 7, Excl ? 8'h01 : 8'h21);
    add_idle("multi_sp_only", 2, 8'h01);
    add_idle("multi_end", 1, 8'h00);
    // Unrecognised byte, then upper-case L.
    add("ignore_x", 1'b0, 1'b1, 8'h78, 8'h00, 8'h00);
    add("upper_l", 1'b0, 1'b1, 8'h4C, 8'h02, 8'h02);
    add_idle("upper_l_hold", Hold - 1, 8'h02);
    add_idle("upper_l_end", 1, 8'h00);
    // Reset mid-hold; a byte during reset is dropped.
    add("midrst_j", 1'b0, 1'b1, 8'h6A, 8'h08, 8'h08);
    add_idle("midrst_hold", 3, 8'h08);
    add("midrst_rst", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    add("midrst_drop", 1'b1, 1'b1, 8'h6A, 8'h00, 8'h00);
    add("midrst_again", 1'b0, 1'b1, 8'h6A, 8'h08, 8'h08);
    add_idle("midrst_hold2", Hold - 1, 8'h08);
    add_idle("midrst_end", 1, 8'h00);

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].v, vecs[k].d);
      check(vecs[k].name, vecs[k].ek, vecs[k].ep);
    end

    // Randomized traffic against the reference model.
    t_now = 0;
    for (int c = 0; c < 800; c++) begin
      bit         r, v;
      logic [7:0] d, ek, ep;
      int         idx;
      r = (c == 0) || ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 1) == 1) ? keys_tbl[$urandom_range(0, 7)] : 8'($urandom);
      if (d == 8'h57 && $urandom_range(0, 1) == 1) d = 8'h77;
      ep = 8'h00;
      if (r) begin
        for (int i = 0; i < 8; i++) have[i] = 1'b0;
      end else if (v) begin
        idx = model_idx(d);
        if (idx >= 0) begin
          ep[idx] = !model_held(idx, t_now);
          if (Excl) for (int i = 0; i < 8; i++) have[i] = 1'b0;
          have[idx]   = 1'b1;
          last_t[idx] = t_now;
        end
      end
      step(r, v, d);
      t_now++;
      for (int i = 0; i < 8; i++) ek[i] = model_held(i, t_now);
      check("random", ek, ep);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
